// File: rtl/controlador_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module   : controlador_multiciclo_if
// Purpose  : Bundle between the multicycle ARM control unit and its datapath.
//            slave  = control unit side (consumes IR/flags/ready, drives controls)
//            master = datapath side (drives IR/flags/ready, consumes controls)
// Signals  : Instr[31:12], ALUFlags{N,Z,C,V}, MemReady          (master -> slave)
//            PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//            ALUControl, ImmSrc, RegSrc, RegWrite, IllegalInstr, State
//                                                               (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface controlador_multiciclo_if #(
  parameter int ALUCTRL_W = 3
);
  logic [31:12]          Instr;
  logic [3:0]            ALUFlags;
  logic                  MemReady;
  logic                  PCWrite;
  logic                  AdrSrc;
  logic                  MemWrite;
  logic                  IRWrite;
  logic [1:0]            ResultSrc;
  logic                  ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [ALUCTRL_W-1:0]  ALUControl;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic                  RegWrite;
  logic                  IllegalInstr;
  logic [3:0]            State;

  modport master (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, IllegalInstr, State
  );

  modport slave (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, IllegalInstr, State
  );
endinterface
`default_nettype wire

// File: rtl/controlador_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : controlador_multiciclo
// Purpose  : Multicycle ARM control unit. A single FSM walks each instruction
//            through FETCH/DECODE/EXECUTE/MEM/WB over a shared memory, with
//            conditional execution against a registered NZCV flag set.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-low
//            bus    - controlador_multiciclo_if.slave (IR/flags/ready in,
//                     datapath controls, IllegalInstr and State out)
// Params   : ALUCTRL_W     - 3 enables EOR; 2 treats EOR as an unknown command
//            MEM_HANDSHAKE - 1 waits on MemReady in memory states; 0 ignores it
// Revision : 1.0 - initial release
// ============================================================================
module controlador_multiciclo #(
  parameter int ALUCTRL_W     = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  controlador_multiciclo_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_ORR = 3'b011;
  localparam logic [2:0] C_ALU_EOR = 3'b100;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;

  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_cond;
  logic        w_rd15;
  logic        w_ready;
  logic        w_n, w_z, w_c, w_v;
  logic        w_condex;

  // Data-processing command decode
  logic        w_cmd_ok;
  logic [2:0]  w_alu_dec;
  logic        w_nowrite;
  logic        w_arith;
  logic [1:0]  w_flagw;

  // Raw (pre-condition) FSM controls
  logic        w_pcw, w_branch, w_regw, w_memw, w_irw, w_flag_en, w_ill;
  logic        w_adrsrc, w_srca;
  logic [1:0]  w_ressrc, w_srcb;
  logic [2:0]  w_alu;

  logic        w_unused;

  assign w_op    = bus.Instr[27:26];
  assign w_funct = bus.Instr[25:20];
  assign w_cond  = bus.Instr[31:28];
  assign w_rd15  = &bus.Instr[15:12];
  assign w_ready = MEM_HANDSHAKE ? bus.MemReady : 1'b1;
  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign w_unused = ^{bus.Instr[19:16], bus.MemReady, w_alu[2]};

  // Condition evaluation against the registered flags
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  // cmd = Funct[4:1]; CMP/TST reuse SUB/AND but never write the register file
  always_comb begin
    w_cmd_ok  = 1'b1;
    w_alu_dec = C_ALU_ADD;
    w_nowrite = 1'b0;
    w_arith   = 1'b0;
    case (w_funct[4:1])
      4'b0100: begin w_alu_dec = C_ALU_ADD; w_arith = 1'b1; end
      4'b0010: begin w_alu_dec = C_ALU_SUB; w_arith = 1'b1; end
      4'b0000: w_alu_dec = C_ALU_AND;
      4'b1100: w_alu_dec = C_ALU_ORR;
      4'b0001: begin
        if (ALUCTRL_W >= 3) w_alu_dec = C_ALU_EOR;
        else                w_cmd_ok  = 1'b0;
      end
      4'b1010: begin w_alu_dec = C_ALU_SUB; w_arith = 1'b1; w_nowrite = 1'b1; end
      4'b1000: begin w_alu_dec = C_ALU_AND; w_nowrite = 1'b1; end
      default: w_cmd_ok = 1'b0;
    endcase
    w_flagw[1] = w_funct[0] | w_nowrite;
    w_flagw[0] = (w_funct[0] | w_nowrite) & w_arith;
  end

  // Next-state and raw control outputs
  always_comb begin
    w_next    = r_state;
    w_pcw     = 1'b0;
    w_branch  = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_irw     = 1'b0;
    w_flag_en = 1'b0;
    w_ill     = 1'b0;
    w_adrsrc  = 1'b0;
    w_srca    = 1'b0;
    w_ressrc  = 2'b00;
    w_srcb    = 2'b00;
    w_alu     = C_ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_srca   = 1'b1;
        w_srcb   = 2'b10;
        w_ressrc = 2'b10;
        if (w_ready) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        case (w_op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        w_srcb = 2'b01;
        w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adrsrc = 1'b1;
        if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_ressrc = 2'b01;
        w_regw   = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe held for the whole wait; the access completes on ready
        w_adrsrc = 1'b1;
        w_memw   = 1'b1;
        if (w_ready) w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        w_srcb = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        if (w_cmd_ok) begin
          w_alu     = w_alu_dec;
          w_flag_en = 1'b1;
          w_next    = w_nowrite ? S_FETCH : S_ALUWB;
        end else begin
          w_next = S_UNKNOWN;
        end
      end
      S_ALUWB: begin
        w_regw = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_srcb   = 2'b01;
        w_ressrc = 2'b10;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_UNKNOWN: begin
        w_ill  = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_en && w_condex) begin
      if (w_flagw[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
      if (w_flagw[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // Outputs are forced low while reset is held so nothing escapes mid-reset.
  // A register write aimed at R15 becomes a PC write instead.
  assign bus.PCWrite      = reset & (w_pcw | ((w_branch | (w_regw & w_rd15)) & w_condex));
  assign bus.RegWrite     = reset & w_regw & w_condex & ~w_rd15;
  assign bus.MemWrite     = reset & w_memw & w_condex;
  assign bus.IRWrite      = reset & w_irw;
  assign bus.AdrSrc       = reset & w_adrsrc;
  assign bus.ALUSrcA      = reset & w_srca;
  assign bus.ResultSrc    = reset ? w_ressrc : 2'b00;
  assign bus.ALUSrcB      = reset ? w_srcb : 2'b00;
  assign bus.ALUControl   = reset ? w_alu[ALUCTRL_W-1:0] : '0;
  assign bus.ImmSrc       = reset ? w_op : 2'b00;
  assign bus.RegSrc       = reset ? {w_op == 2'b10, w_op == 2'b01} : 2'b00;
  assign bus.IllegalInstr = reset & w_ill;
  assign bus.State        = r_state;

endmodule
`default_nettype wire
